// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS core. It sequences fetch, decode,
// execute, memory and writeback over the shared ALU, memory port and register
// file. The state register and the latched opcode/funct are held in flops.
// The control outputs are decoded from the current state. The memory handshake
// and the branch condition are folded into the outputs in the same cycle.
module multicycle_ctrl #(
    parameter int         STATE_W = 4,
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110,
    parameter logic [2:0] ALU_SLT = 3'b111,
    parameter logic [2:0] ALU_AND = 3'b000,
    parameter logic [2:0] ALU_OR  = 3'b001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_ctrl,
    output logic [1:0]         pc_src,
    output logic               ext_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU= 6'h09;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP   = 4'd11
    } state_t;

    state_t     state_q;
    logic [5:0] op_q, funct_q;
    logic       r_funct_ok;
    logic       op_ok;

    // Legality of the instruction currently on the IR, used only in DECODE
    always_comb begin
        r_funct_ok = funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
        op_ok      = op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                OP_SLTI, OP_ANDI, OP_ORI, OP_J}
                     || (op == OP_R && r_funct_ok);
    end

    // State sequencing and opcode capture; codes 12-15 fall back to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            case (state_q)
                FETCH:  if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    op_q    <= op;
                    funct_q <= funct;
                    if (!op_ok)
                        state_q <= FETCH;
                    else case (op)
                        OP_LW, OP_SW:   state_q <= MEMADR;
                        OP_R:           state_q <= EXEC;
                        OP_BEQ, OP_BNE: state_q <= BRANCH;
                        OP_J:           state_q <= JUMP;
                        default:        state_q <= IEXEC;
                    endcase
                end
                MEMADR: state_q <= (op_q == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (mem_ready) state_q <= MEMWB;
                MEMWR:  if (mem_ready) state_q <= FETCH;
                EXEC:   state_q <= ALUWB;
                IEXEC:  state_q <= IWB;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Output decode. The mem_ready and zero inputs must act in the cycle they
    // are presented, so this decode is combinational. Reset masks every enable.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        pc_src     = 2'b00;
        ext_op     = 1'b1;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !op_ok;
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    case (funct_q)
                        6'h22, 6'h23: alu_ctrl = ALU_SUB;
                        6'h24:        alu_ctrl = ALU_AND;
                        6'h25:        alu_ctrl = ALU_OR;
                        6'h2A:        alu_ctrl = ALU_SLT;
                        default:      alu_ctrl = ALU_ADD;
                    endcase
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_en     = (op_q == OP_BEQ) ? zero : !zero;
                end
                IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (op_q)
                        OP_SLTI: alu_ctrl = ALU_SLT;
                        OP_ANDI: alu_ctrl = ALU_AND;
                        OP_ORI:  alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                    ext_op = !(op_q == OP_ANDI || op_q == OP_ORI);
                end
                IWB:  reg_write = 1'b1;
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Expected values are hand-derived.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       ext_op, illegal_op;
    logic [3:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_src(pc_src), .ext_op(ext_op),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance one clock edge, then let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // no write enable and no illegal pulse
    task automatic chk_quiet(input string tag);
        chk(tag, {28'd0, pc_en, ir_write, mem_write, reg_write, illegal_op}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk_quiet("reset_enables");
        chk("reset_ext_op", ext_op, 1);
        chk("reset_alu_ctrl", alu_ctrl, 3'b010);
        tick();
        chk("reset_state", state, 0);
        tick();
        reset = 1'b0; #1;

        // R-type add: 0,1,6,7,0
        chk("r_fetch_state", state, 0);
        chk("r_fetch_en", {pc_en, ir_write, alu_src_b}, {1'b1, 1'b1, 2'b01});
        tick();
        chk("r_decode_state", state, 1);
        chk("r_decode_srcb", alu_src_b, 2'b11);
        chk("r_decode_we", reg_write, 0);
        tick();
        chk("r_exec_state", state, 6);
        chk("r_exec_alu", {alu_src_a, alu_src_b, alu_ctrl}, {1'b1, 2'b00, 3'b010});
        chk("r_exec_we", {reg_write, reg_dst}, 2'b00);
        tick();
        chk("r_aluwb_state", state, 7);
        chk("r_aluwb_we", {reg_write, reg_dst}, 2'b11);
        tick();
        chk("r_back_fetch", state, 0);

        // R-type sub; funct changed after DECODE must not matter
        funct = 6'h22;
        tick(); tick();
        funct = 6'h24; #1;
        chk("sub_exec_state", state, 6);
        chk("sub_alu", alu_ctrl, 3'b110);
        tick(); tick();

        // fetch stall
        op = 6'h23; mem_ready = 1'b0; #1;
        chk("fetch_stall_en", {pc_en, ir_write}, 2'b00);
        tick();
        chk("fetch_stall_state", state, 0);
        mem_ready = 1'b1; #1;
        chk("fetch_go_en", {pc_en, ir_write}, 2'b11);

        // lw with three wait cycles in MEMRD
        tick();
        chk("lw_decode", state, 1);
        tick();
        chk("lw_memadr", {state, alu_src_a, alu_src_b, ext_op, alu_ctrl},
            {4'd2, 1'b1, 2'b10, 1'b1, 3'b010});
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk($sformatf("lw_memrd%0d", i), {state, iord, mem_write, reg_write},
                {4'd3, 1'b1, 1'b0, 1'b0});
        end
        tick();
        chk("lw_memwb", {state, reg_write, mem_to_reg, mem_write}, {4'd4, 1'b1, 1'b1, 1'b0});
        tick();
        chk("lw_done", {state, reg_write}, {4'd0, 1'b0});

        // beq taken
        op = 6'h04; zero = 1'b1;
        tick(); tick();
        chk("beq_branch", {state, pc_en, pc_src, alu_ctrl}, {4'd8, 1'b1, 2'b01, 3'b110});
        tick();
        chk("beq_done", state, 0);

        // bne with zero=1: not taken
        op = 6'h05;
        tick(); tick();
        chk("bne_branch", {state, pc_en, pc_src}, {4'd8, 1'b0, 2'b01});
        tick();
        chk("bne_done", state, 0);
        zero = 1'b0;

        // andi: zero-extend, AND
        op = 6'h0C;
        tick(); tick();
        chk("andi_iexec", {state, ext_op, alu_ctrl, alu_src_b}, {4'd9, 1'b0, 3'b000, 2'b10});
        tick();
        chk("andi_iwb", {state, reg_write, reg_dst}, {4'd10, 1'b1, 1'b0});
        tick();

        // addi: sign-extend, ADD
        op = 6'h08;
        tick(); tick();
        chk("addi_iexec", {state, ext_op, alu_ctrl}, {4'd9, 1'b1, 3'b010});
        tick(); tick();

        // jump
        op = 6'h02;
        tick(); tick();
        chk("j_jump", {state, pc_en, pc_src}, {4'd11, 1'b1, 2'b10});
        tick();
        chk("j_done", state, 0);

        // illegal opcode
        op = 6'h3F;
        tick();
        chk("ill_op_pulse", {state, illegal_op, pc_en}, {4'd1, 1'b1, 1'b0});
        tick();
        chk("ill_op_fetch", {state, illegal_op}, {4'd0, 1'b0});

        // illegal R funct
        op = 6'h00; funct = 6'h08;
        tick();
        chk("ill_fn_pulse", {state, illegal_op}, {4'd1, 1'b1});
        chk("ill_fn_we", {reg_write, mem_write, ir_write}, 3'b000);
        tick();
        chk("ill_fn_fetch", {state, illegal_op}, {4'd0, 1'b0});

        // sw stalled in MEMWR, then reset aborts it
        op = 6'h2B; funct = 6'h20;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_memwr", {state, mem_write, iord}, {4'd5, 1'b1, 1'b1});
        tick();
        chk("sw_memwr_hold", {state, mem_write}, {4'd5, 1'b1});
        reset = 1'b1; #1;
        chk("sw_reset_mw", mem_write, 0);
        chk_quiet("sw_reset_quiet");
        tick();
        chk("sw_reset_state", state, 0);
        reset = 1'b0; mem_ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
